fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared constants for the instruction fetch unit.
//
// Contents:
//   DEF_*            default values for the fetch_unit parameters
//   MEM_EN / MEM_DIS active-low memory control levels
//   UNDEFINE         fill value for unused memory write data
package fetch_pkg;

    localparam int          DEF_PC_W     = 32;
    localparam int          DEF_ADDR_W   = 11;
    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'd0;

    // Memory control pins are active-low.
    localparam logic MEM_EN  = 1'b0;
    localparam logic MEM_DIS = 1'b1;

    localparam logic UNDEFINE = 1'b0;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- synchronous circular FIFO with flush.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (empties the FIFO)
//   flush  synchronous flush; same effect as rst, wins over push/pop
//   push   write wdata at the tail (ignored when full and not popping)
//   wdata  data to write
//   pop    advance the head (ignored when empty)
//   rdata  data at the head; meaningful only while count != 0
//   count  number of occupied entries, 0..DEPTH
//
// Handshake: push and pop are plain strobes; the caller owns flow control.
// A push and a pop in the same cycle leave count unchanged.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        // A full FIFO may still accept a push when the head leaves this cycle.
        do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
        rdata   = mem[rd_ptr];
    end

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch with a small decoupling queue.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   redirect_valid/pc   branch/jump redirect: flush, kill in-flight, reload PC
//   im_cen/wen/oen      active-low memory controls (read-only use)
//   im_addr             memory word address (low ADDR_W bits of fetch_pc)
//   im_datain           memory write data, tied to zero
//   im_dataout          memory read data, valid the cycle after a request
//   out_valid/ready     valid/ready handshake towards decode
//   out_instr/pc        instruction and its word address at the queue head
//   out_pc_next         out_pc + 1
//
// Handshake: an instruction transfers to decode in every cycle where
// out_valid and out_ready are both 1; out_valid does not depend on out_ready.
//
// At most one request is ever in flight (memory latency is one cycle).
// A request issues only while queue occupancy plus the in-flight request is
// below DEPTH, so every returning word has a guaranteed slot even if nothing
// pops; this makes overflow impossible without looking at the pop strobe.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              DATA_W   = DEF_DATA_W,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              im_cen,
    output logic              im_wen,
    output logic              im_oen,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_datain,
    input  logic [DATA_W-1:0] im_dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_next
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]        fetch_pc;
    logic                   inflight;
    logic [PC_W-1:0]        inflight_pc;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       credit_used;
    logic [DATA_W+PC_W-1:0] fifo_rdata;
    logic                   issue;
    logic                   push;
    logic                   pop;

    always_comb begin
        credit_used = fifo_count + CNT_W'(inflight);
        issue       = !rst && !redirect_valid && (credit_used < CNT_W'(DEPTH));
        // A redirect kills the word returning this cycle.
        push        = inflight && !redirect_valid && !rst;
        out_valid   = (fifo_count != '0) && !redirect_valid && !rst;
        pop         = out_valid && out_ready;

        im_cen      = issue ? MEM_EN : MEM_DIS;
        im_addr     = fetch_pc[ADDR_W-1:0];

        out_instr   = fifo_rdata[DATA_W+PC_W-1:PC_W];
        out_pc      = fifo_rdata[PC_W-1:0];
        out_pc_next = out_pc + PC_W'(1);
    end

    assign im_wen    = MEM_DIS;
    assign im_oen    = MEM_EN;
    assign im_datain = {DATA_W{UNDEFINE}};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end

    // Tag for the returning word; only read while inflight is set.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_W + PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({im_dataout, inflight_pc}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

endmodule
